// File: rtl/i2s_dac_pkg.sv
// Shared constants and small helpers for the I2S DAC transmitter slice.
package i2s_dac_pkg;

  localparam int DAC_WIDTH       = 24;
  localparam int DAC_SCLK_DIV    = 4;
  // Two channels, each DAC_WIDTH bits, each bit 2*DAC_SCLK_DIV clk cycles long.
  localparam int SAMPLE_RATE_DIV = 2 * DAC_WIDTH * 2 * DAC_SCLK_DIV;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  function automatic i2s_chan_e chan_for_bit(input int bit_idx, input int width);
    return (bit_idx >= width) ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_dac_transmitter_if.sv
// Sample/serial bus of the I2S DAC transmitter: master supplies samples, slave serialises them.
interface i2s_dac_transmitter_if
  import i2s_dac_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH
);

  logic                    enable;
  logic signed [WIDTH-1:0] left_data;
  logic signed [WIDTH-1:0] right_data;
  logic                    sclk;
  logic                    lrclk;
  logic                    sd;
  logic                    sample_req;

  modport master (
    output enable, left_data, right_data,
    input  sclk, lrclk, sd, sample_req
  );

  modport slave (
    input  enable, left_data, right_data,
    output sclk, lrclk, sd, sample_req
  );

endinterface

// File: rtl/i2s_dac_sclk_div.sv
// Bit-clock divider: sclk toggles every SCLK_DIV enabled clk cycles, with strobes that
// flag the clk edge on which sclk is about to rise or fall and the enable-start edge.
module i2s_dac_sclk_div
  import i2s_dac_pkg::*;
#(
  parameter int SCLK_DIV = DAC_SCLK_DIV
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic start
);

  localparam int              CNT_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             active;
  logic             tick;

  // The start edge holds the count at zero so the first rise lands SCLK_DIV edges later.
  assign start = enable && !active;
  assign tick  = enable && active && (div_cnt == CNT_LAST);
  assign rise  = tick && !sclk;
  assign fall  = tick && sclk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active  <= 1'b0;
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!enable) begin
      active  <= 1'b0;
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!active) begin
      active  <= 1'b1;
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_dac_transmitter.sv
// Stereo I2S DAC transmitter. Default build is left-justified; define I2S_DAC_I2S_DELAY_EN
// for standard I2S alignment (MSB delayed one bit clock after the lrclk edge).
module i2s_dac_transmitter
  import i2s_dac_pkg::*;
#(
  parameter int WIDTH    = DAC_WIDTH,
  parameter int SCLK_DIV = DAC_SCLK_DIV
) (
  input  logic clk,
  input  logic rstn,
  i2s_dac_transmitter_if.slave bus
);

  localparam int               FRAME_BITS = 2 * WIDTH;
  localparam int               BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  logic                  sclk_q;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  frame_start;
  logic                  frame_wrap;
  logic                  latch;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic [FRAME_BITS-1:0] shadow;
  logic [FRAME_BITS-1:0] shadow_nxt;
  logic                  lrclk_q;
  logic                  sd_q;
  logic                  req_q;

  i2s_dac_sclk_div #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_div (
    .clk    (clk),
    .rstn   (rstn),
    .enable (bus.enable),
    .sclk   (sclk_q),
    .rise   (sclk_rise),
    .fall   (sclk_fall),
    .start  (frame_start)
  );

  // Both strobes come from the same divider tick; seeing them together means sclk is corrupt.
  always_comb assert (!(sclk_rise && sclk_fall));

  // Shadow register holds the frame MSB-first: left word on top, shifted out one bit per fall.
  assign frame_wrap = sclk_fall && (bit_cnt == BIT_LAST);
  assign latch      = frame_start || frame_wrap;
  assign shadow_nxt = latch ? {bus.left_data, bus.right_data}
                            : {shadow[FRAME_BITS-2:0], 1'b0};
  assign bit_nxt    = latch ? '0 : bit_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
      shadow  <= '0;
      lrclk_q <= 1'b0;
      sd_q    <= 1'b0;
      req_q   <= 1'b0;
    end else if (!bus.enable) begin
      bit_cnt <= '0;
      shadow  <= '0;
      lrclk_q <= 1'b0;
      sd_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      req_q <= latch;
      if (latch || sclk_fall) begin
        bit_cnt <= bit_nxt;
        shadow  <= shadow_nxt;
        lrclk_q <= chan_for_bit(int'(bit_nxt), WIDTH);
`ifdef I2S_DAC_I2S_DELAY_EN
        // The bit leaving the shadow now is the previous period's bit; a fresh start has none.
        sd_q    <= frame_start ? 1'b0 : shadow[FRAME_BITS-1];
`else
        sd_q    <= shadow_nxt[FRAME_BITS-1];
`endif
      end
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.lrclk      = lrclk_q;
  assign bus.sd         = sd_q;
  assign bus.sample_req = req_q;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Scoreboard bench for i2s_dac_transmitter: a cycle-count reference model predicts outputs
// and latched frames; a monitor deserialises sd on sclk rising edges and checks timing.
module tb_i2s_dac_transmitter;
  import i2s_dac_pkg::*;

  localparam int W     = DAC_WIDTH;
  localparam int S     = DAC_SCLK_DIV;
  localparam int FRAME = SAMPLE_RATE_DIV;
  localparam int FB    = 2 * W;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  i2s_dac_transmitter_if #(.WIDTH(W)) bus ();

  i2s_dac_transmitter #(.WIDTH(W), .SCLK_DIV(S)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit run_chk  = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the count of enabled cycles since the start edge.
  int             m_cnt   = -1;
  int             m_p;
  logic           m_sd;
  logic [FB-1:0]  cur_w   = '0;
  logic [FB-1:0]  prev_w  = '0;
  logic [3:0]     exp_out = '0;
  logic [FB-1:0]  exp_q[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn || !bus.enable) begin
      m_cnt   = -1;
      exp_q.delete();
      exp_out = '0;
    end else begin
      m_cnt++;
      if (m_cnt % FRAME == 0) begin
        prev_w = cur_w;
        cur_w  = {bus.left_data, bus.right_data};
        exp_q.push_back(cur_w);
      end
      m_p = (m_cnt / (2 * S)) % FB;
`ifdef I2S_DAC_I2S_DELAY_EN
      if (m_p == 0) m_sd = (m_cnt < FRAME) ? 1'b0 : prev_w[0];
      else          m_sd = cur_w[FB - m_p];
`else
      m_sd = cur_w[FB - 1 - m_p];
`endif
      exp_out = {((m_cnt / S) % 2) == 1, m_p >= W, m_sd, (m_cnt % FRAME) == 0};
    end
  end

  always @(negedge clk)
    if (run_chk)
      check("outputs", {bus.sclk, bus.lrclk, bus.sd, bus.sample_req}, exp_out);

  // Monitor: capture on sclk rising, pop the expected frame once a whole word is seen.
  logic          prev_sclk = 1'b0;
  logic          prev_lr   = 1'b0;
  int            t_req, t_rise, t_lrr, t_lrh;
  bit            have_req = 0, have_rise = 0, first_rise = 0, have_lrr = 0, have_lrh = 0;
  int            idx = 0;
  bit            pend = 0;
  logic [FB-1:0] bits = '0;
  int            words_cmp = 0;

  task automatic compare_word(input logic [FB-1:0] got);
    logic [FB-1:0] e;
    check("word_available", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      words_cmp++;
      check("left_word",  got[FB-1:W], e[FB-1:W]);
      check("right_word", got[W-1:0],  e[W-1:0]);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn || !bus.enable) begin
      have_req = 0; have_rise = 0; first_rise = 0;
      have_lrr = 0; have_lrh = 0; idx = 0; pend = 0;
    end else if (run_chk) begin
      if (bus.sample_req) begin
        if (have_req) check("req_period", cyc - t_req, FRAME);
        else          first_rise = 1;
        have_req = 1; t_req = cyc; idx = 0;
      end
      if (bus.sclk && !prev_sclk) begin
        if (first_rise)     check("first_rise_delay", cyc - t_req, S);
        else if (have_rise) check("sclk_period", cyc - t_rise, 2 * S);
        first_rise = 0; have_rise = 1; t_rise = cyc;
        if (idx < FB) begin
`ifdef I2S_DAC_I2S_DELAY_EN
          if (idx == 0) begin
            if (pend) begin
              bits[0] = bus.sd;
              compare_word(bits);
              pend = 0;
            end
          end else begin
            bits[FB - idx] = bus.sd;
            if (idx == FB - 1) pend = 1;
          end
`else
          bits[FB - 1 - idx] = bus.sd;
          if (idx == FB - 1) compare_word(bits);
`endif
        end
        idx++;
      end
      if (bus.lrclk && !prev_lr) begin
        if (have_lrr) check("lrclk_period", cyc - t_lrr, FRAME);
        have_lrr = 1; t_lrr = cyc; have_lrh = 1; t_lrh = cyc;
      end
      if (!bus.lrclk && prev_lr && have_lrh) check("lrclk_high", cyc - t_lrh, W * 2 * S);
    end
    prev_sclk = bus.sclk;
    prev_lr   = bus.lrclk;
  end

  // Stimulus helpers: drive just after the active edge.
  task automatic tick(input int n, input int chg_pct);
    repeat (n) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < chg_pct) begin
        bus.left_data  = W'($urandom);
        bus.right_data = W'($urandom);
      end
    end
  endtask

  task automatic wait_period(input int p, input string name);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(posedge clk); #1;
      if (m_cnt >= 0 && (m_cnt % FRAME) == p * 2 * S) hit = 1;
    end
    check(name, hit, 1);
  endtask

  initial begin
    bit hit;
    rstn = 1'b1;
    bus.enable = 1'b0;
    bus.left_data = '0;
    bus.right_data = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.sclk, bus.lrclk, bus.sd, bus.sample_req}, 4'b0);
    run_chk = 1'b1;
    rstn = 1'b1;
    tick(3, 0);

    // Boundary words, then a word swapped mid-frame at bit 5.
    bus.left_data  = 24'sh800001;
    bus.right_data = 24'sh7FFFFE;
    bus.enable     = 1'b1;
    tick(1, 0);
    bus.left_data  = 24'shA5A5A5;
    bus.right_data = W'($urandom);
    wait_period(0, "sync_frame1");
    bus.left_data  = 24'sh123456;
    bus.right_data = W'($urandom);
    wait_period(0, "sync_frame2");
    wait_period(5, "sync_bit5");
    bus.left_data  = 24'sh654321;
    wait_period(0, "sync_frame3");
    tick(2 * FRAME, 3);

    // Enable dropped for 10 clk at bit 30.
    wait_period(30, "sync_bit30");
    bus.enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_outputs", {bus.sclk, bus.lrclk, bus.sd, bus.sample_req}, 4'b0);
    repeat (9) @(posedge clk);
    #1 bus.enable = 1'b1;
    tick(2 * FRAME, 2);

    // Asynchronous reset while sclk and lrclk are both high.
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(posedge clk); #1;
      if (exp_out[3] && exp_out[2]) hit = 1;
    end
    check("sync_areset", hit, 1);
    #2 rstn = 1'b0;
    #1 check("areset_outputs", {bus.sclk, bus.lrclk, bus.sd, bus.sample_req}, 4'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick(2 * FRAME, 2);

    // Random short enable drops.
    for (int k = 0; k < 4; k++) begin
      tick($urandom_range(700, 50), 2);
      bus.enable = 1'b0;
      tick($urandom_range(3, 1), 0);
      bus.enable = 1'b1;
    end
    tick(2 * FRAME + 10, 2);

    check("words_compared", words_cmp >= 5, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_dac_transmitter.md
I2S_DAC_TRANSMITTER -- requirements
Module: i2s_dac_transmitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning bits per channel sample.
REQ-002 The block SHALL have parameter SCLK_DIV, default 4, meaning sclk half-period in clk cycles; legal range is 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; one clock, rstn asynchronous active-low.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: transmit enable; low idles all outputs.
REQ-006 The block SHALL have port left_data, input, signed WIDTH bits: left sample, two's complement.
REQ-007 The block SHALL have port right_data, input, signed WIDTH bits: right sample, two's complement.
REQ-008 The block SHALL have port sclk, output, 1 bit: DAC serial bit clock.
REQ-009 The block SHALL have port lrclk, output, 1 bit: channel select; 0 = left, 1 = right.
REQ-010 The block SHALL have port sd, output, 1 bit: serial data, MSB first.
REQ-011 The block SHALL have port sample_req, output, 1 bit: one-clk pulse when both samples are latched.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from input to output.
REQ-013 sclk SHALL toggle every SCLK_DIV enabled clk cycles, giving a period of 2*SCLK_DIV clk cycles and 50% duty.
REQ-014 sclk SHALL start low, and its first rising edge SHALL occur SCLK_DIV cycles after enable is sampled high.
REQ-015 A frame SHALL be 2*WIDTH sclk periods, with bit counter 0..2*WIDTH-1 wrapping to 0 with no gap.
REQ-016 lrclk SHALL be 0 for bit counts 0..WIDTH-1 and 1 for WIDTH..2*WIDTH-1.
REQ-017 lrclk and sd SHALL change only coincident with sclk falling edges (or the enable-start cycle); the DAC samples on sclk rising.
REQ-018 On the first enabled cycle and at every frame wrap, the block SHALL latch left_data and right_data into a 2*WIDTH shadow shift register and pulse sample_req for exactly 1 clk.
REQ-019 Input changes between latch points SHALL NOT affect the frame in flight.
REQ-020 In I2S mode, sd in bit period n SHALL carry shift-register bit n-1: the MSB appears one sclk after the lrclk edge, and the right LSB appears in period 0 of the next frame.
REQ-021 In the I2S first frame after enable or reset, sd in period 0 SHALL be 0.
REQ-022 When enable is sampled low, the next clk SHALL force sclk=0, lrclk=0, sd=0 and sample_req=0, clear the counters and abort the frame.
REQ-023 Re-assertion of enable SHALL restart at bit count 0 per REQ-014 and REQ-018.

Reset
REQ-024 rstn low SHALL asynchronously clear sclk, lrclk, sd, sample_req, the divider counter, the bit counter and the shadow register to 0.
REQ-025 Release of rstn SHALL be synchronous to clk.
REQ-026 Reset mid-frame SHALL discard the frame, and the first cycle after release with enable=1 SHALL behave as the enable-start cycle.

Configuration
REQ-027 Macro I2S_DAC_I2S_DELAY_EN defined SHALL select standard I2S alignment (one-bit MSB delay, REQ-020 and REQ-021).
REQ-028 Without I2S_DAC_I2S_DELAY_EN, the block SHALL use left-justified alignment: sd in period n carries bit n, and the MSB is valid in the same period as the lrclk edge.

Structure
REQ-029 Shared package i2s_dac_pkg SHALL hold constants DAC_WIDTH=24, DAC_SCLK_DIV=4 and SAMPLE_RATE_DIV=384 (clk cycles per frame at the defaults).
REQ-030 The block SHALL contain one sub-module, i2s_dac_sclk_div, which generates sclk and one-cycle rise/fall strobes from clk, enable and rstn.

Verification
REQ-031 Period check: defaults, enable=1 -> sample_req pulses every 384 clk, lrclk period is 384 clk with 192 high, and sclk period is 8 clk.
REQ-032 I2S data check: I2S_DAC_I2S_DELAY_EN defined, left=0x800001, right=0x7FFFFE -> 48 bits captured on sclk rising edges, offset by 1, decode to 0x800001 (lrclk=0) and 0x7FFFFE (lrclk=1).
REQ-033 Left-justified check: macro undefined, left=0xA5A5A5 -> first bit after lrclk falls is 1 and the word decodes to 0xA5A5A5 without offset.
REQ-034 Mid-frame input change: left_data changes from 0x123456 to 0x654321 at bit 5 -> the current frame sends 0x123456 and the next frame sends 0x654321.
REQ-035 Enable drop: enable low for 10 clk at bit 30 -> outputs 0 on the next clk; on re-enable, sample_req pulses on the first enabled clk and sclk first rises 4 clk later.
REQ-036 Async reset: rstn low mid-frame -> all outputs 0 with no clk edge; after release, the frame restarts at bit 0 with sample_req pulsed.
